// File: rtl/fp_sched_pkg.sv
// Shared constants and payload types for the FP adder scheduler.
package fp_sched_pkg;

    // IEEE-754 single-precision field layout.
    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_W    = 23;

    // Handy encodings for directed stimulus.
    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

    // Widest requester ID (up to 8 requesters).
    localparam int unsigned ID_MAX_W = 3;

    // Response payload {id, data} at its widest.
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [FP_W-1:0]     data;
    } resp_t;

    // Width of a packed {id, data} response entry for a given configuration.
    function automatic int unsigned resp_width(input int unsigned idw, input int unsigned xlen);
        return idw + xlen;
    endfunction

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Client-side request/response handshakes of the FP adder scheduler.
interface fp_add_scheduler_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) ();

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic [XLEN-1:0]      resp_data;
    logic                 resp_ready;

    // Compute clients: issue requests, consume responses.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    // Scheduler: grants requests, produces responses.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search just after the last winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;
    logic           found;

    // Last-winner pointer; reset to NREQ-1 so requester 0 is checked first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (|grant) begin
            ptr <= grant_idx;
        end
    end

    // Scan ptr+1 .. ptr+NREQ (mod NREQ) and take the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Time-shares one external FP adder among NREQ requesters with credit-based issue.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_scheduler_if.slave   bus,
    output logic [XLEN-1:0]     add_a,
    output logic [XLEN-1:0]     add_b,
    input  logic [XLEN-1:0]     add_result
);

    // Stage 0 is aligned with add_a/add_b, the last stage with add_result.
    localparam int unsigned NSTG    = ADD_LAT + 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned USED_W  = $clog2(DEPTH + NSTG + 1);
    localparam int unsigned ENTRY_W = resp_width(IDW, XLEN);

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    logic               issue_en;
    logic               fire;

    logic [NSTG-1:0]    tag_vld;
    logic [IDW-1:0]     tag_id [NSTG];

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;

    logic [USED_W-1:0]  inflight;
    logic [USED_W-1:0]  used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits: every accepted op owns a FIFO slot until it is popped.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < NSTG; i++) begin
            inflight = inflight + USED_W'(tag_vld[i]);
        end
        used     = USED_W'(fifo_count) + inflight;
        pop      = (fifo_count != '0) && bus.resp_ready;
        issue_en = !rst && ((used < USED_W'(DEPTH)) || pop);
        push     = tag_vld[NSTG-1];
        fire     = |grant;
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .enable    (issue_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;

    // Operand registers: load the winner's operands, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a <= '0;
            add_b <= '0;
        end else if (fire) begin
            add_a <= bus.req_a[grant_idx*XLEN +: XLEN];
            add_b <= bus.req_b[grant_idx*XLEN +: XLEN];
        end
    end

    // Tag pipe: carries the requester ID alongside the adder's latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i < NSTG; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[NSTG-2:0], fire};
            tag_id[0] <= grant_idx;
            for (int unsigned i = 1; i < NSTG; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Response FIFO: capture {id, sum} when the tag leaves the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_id[NSTG-1], add_result};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // First-word fall-through head presentation.
    always_comb begin
        head           = fifo_mem[rd_ptr];
        bus.resp_valid = (fifo_count != '0);
        bus.resp_id    = head[ENTRY_W-1 -: IDW];
        bus.resp_data  = head[XLEN-1:0];
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized and directed bench for fp_add_scheduler with a queue-based reference model.
module tb_fp_add_scheduler;
    import fp_sched_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned IDW     = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] add_result;
    logic [XLEN-1:0] add_pipe [ADD_LAT];

    fp_add_scheduler_if #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) bus ();

    fp_add_scheduler #(
        .XLEN(XLEN), .NREQ(NREQ), .ADD_LAT(ADD_LAT), .DEPTH(DEPTH), .IDW(IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result)
    );

    always #5 clk = ~clk;

    // Reference single-precision add through double arithmetic (normals only, truncating).
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[EXP_MSB:0] == '0) return 0.0;
        d = {x[SIGN_BIT], 11'(x[EXP_MSB:EXP_LSB]) + 11'd896, x[MAN_W-1:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'(100 + $urandom_range(0, 50));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Behavioural adder: ADD_LAT register stages after the operand registers.
    always @(posedge clk) begin
        add_pipe[0] <= fadd(add_a, add_b);
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_result = add_pipe[ADD_LAT-1];

    typedef struct {
        resp_t r;
        int    rdy;
    } sb_t;

    sb_t             sbq[$];
    int              grant_log[$];
    int              checks;
    int              failures;
    int              cyc;
    int              rr_last;
    int              n_pop;
    int              sent;
    int              base;
    logic [NREQ-1:0] hs_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*XLEN +: XLEN] = a;
        bus.req_b[i*XLEN +: XLEN] = b;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_resp_valid", bus.resp_valid, 0);
        check_eq("rst_resp_id", bus.resp_id, 0);
        check_eq("rst_add_a", add_a, 0);
        check_eq("rst_add_b", add_b, 0);
    endtask

    // One clock: compare outputs at negedge against the model, then advance it.
    task automatic tick();
        logic [NREQ-1:0] exp_grant;
        logic            head_ok;
        logic            pop;
        logic            allow;
        int              id;
        int              j;
        sb_t             e;
        @(negedge clk);
        head_ok = (sbq.size() > 0) && (sbq[0].rdy <= cyc);
        check_eq("resp_valid", bus.resp_valid, head_ok);
        if (head_ok) begin
            check_eq("resp_id", bus.resp_id, sbq[0].r.id);
            check_eq("resp_data", bus.resp_data, sbq[0].r.data);
        end
        pop   = head_ok && bus.resp_ready;
        allow = (sbq.size() < DEPTH) || pop;
        exp_grant = '0;
        id = -1;
        if (allow) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (rr_last + k) % NREQ;
                if (id < 0 && bus.req_valid[j]) begin
                    id = j;
                    exp_grant[j] = 1'b1;
                end
            end
        end
        check_eq("req_ready", bus.req_ready, exp_grant);
        check_eq("push_full", dut.push && (dut.fifo_count == DEPTH), 0);
        hs_last = bus.req_valid & bus.req_ready;
        if (pop) begin
            void'(sbq.pop_front());
            n_pop++;
        end
        if (id >= 0) begin
            e.r.id   = ID_MAX_W'(id);
            e.r.data = fadd(bus.req_a[id*XLEN +: XLEN], bus.req_b[id*XLEN +: XLEN]);
            e.rdy    = cyc + ADD_LAT + 2;
            sbq.push_back(e);
            grant_log.push_back(id);
            rr_last = id;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; n_pop = 0; rr_last = NREQ - 1;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Single request: 1.0 + 2.0 from requester 0.
        set_op(0, FP_ONE, FP_TWO);
        bus.req_valid = 4'b0001;
        bus.resp_ready = 1'b1;
        tick();
        check_eq("single_hs", hs_last, 4'b0001);
        bus.req_valid = '0;
        repeat (ADD_LAT + 1) tick();
        check_eq("single_valid", bus.resp_valid, 1);
        check_eq("single_id", bus.resp_id, 0);
        check_eq("single_data", bus.resp_data, FP_THREE);
        tick();
        check_eq("single_drop", bus.resp_valid, 0);

        // Backpressure: requester 2 streams 10 ops while the consumer stalls.
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        set_op(2, rand_fp(), rand_fp());
        sent = 0;
        base = n_pop;
        repeat (8) begin
            tick();
            if (hs_last[2]) begin sent++; set_op(2, rand_fp(), rand_fp()); end
        end
        check_eq("bp_accepted", sent, DEPTH);
        check_eq("bp_stall", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        #1;
        check_eq("pop_issue_rdy", bus.req_ready, 4'b0100);
        check_eq("pop_issue_vld", bus.resp_valid, 1);
        for (int n = 0; n < 100 && !(sent == 10 && sbq.size() == 0); n++) begin
            tick();
            if (hs_last[2]) begin
                sent++;
                if (sent == 10) bus.req_valid = '0;
                else set_op(2, rand_fp(), rand_fp());
            end
        end
        check_eq("bp_total", sent, 10);
        check_eq("bp_resp", n_pop - base, 10);
        check_eq("bp_drained", sbq.size(), 0);

        // Reset while three ops are outstanding and unconsumed.
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        sent = 0;
        repeat (3) begin
            set_op(1, rand_fp(), rand_fp());
            tick();
            if (hs_last[1]) sent++;
        end
        check_eq("mid_issued", sent, 3);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        rr_last = NREQ - 1;
        cyc++;
        repeat (4) tick();

        // Pointer wrap: only requesters 0 and 3; fresh pointer grants 0 first.
        bus.resp_ready = 1'b1;
        set_op(0, rand_fp(), rand_fp());
        set_op(3, rand_fp(), rand_fp());
        bus.req_valid = 4'b1001;
        grant_log.delete();
        repeat (6) tick();
        check_eq("wrap_cnt", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check_eq("wrap_grant", grant_log[k], (k % 2 == 0) ? 0 : 3);
        bus.req_valid = '0;
        repeat (4) tick();

        // Fairness: all four requesters add 1.5 + 1.5 continuously.
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h3FC0_0000, 32'h3FC0_0000);
        bus.req_valid = 4'b1111;
        grant_log.delete();
        repeat (12) tick();
        check_eq("fair_cnt", grant_log.size(), 12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            check_eq("fair_grant", grant_log[k], k % NREQ);
        bus.req_valid = '0;
        base = n_pop;
        repeat (ADD_LAT + 4) tick();
        check_eq("fair_drain", sbq.size(), 0);

        // Random traffic with random consumer stalls.
        repeat (400) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, rand_fp(), rand_fp());
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        repeat (DEPTH + ADD_LAT + 4) tick();
        check_eq("rand_drain", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
